// File: rtl/xorshift_pkg.sv
// xorshift_pkg: shared word type, default seeds and shift constants for xorshift128
package xorshift_pkg;
   typedef logic [31:0] word_t;
   localparam word_t DEF_X = 32'd123456789;
   localparam word_t DEF_Y = 32'd362436069;
   localparam word_t DEF_Z = 32'd521288629;
   localparam word_t DEF_W = 32'd88675123;
   localparam int SH_A = 11;
   localparam int SH_B = 8;
   localparam int SH_C = 19;
endpackage

// File: rtl/xorshift128_step.sv
// xorshift128_step: combinational next-state of the 128-bit {x,y,z,w} state
module xorshift128_step import xorshift_pkg::*; (
   input  logic [127:0] s,
   output logic [127:0] n
);
   word_t t;
   assign t = s[127:96] ^ (s[127:96] << SH_A);
   assign n = {s[95:0], s[31:0] ^ (s[31:0] >> SH_C) ^ t ^ (t >> SH_B)};
endmodule

// File: rtl/xorshift.sv
// xorshift: free-running xorshift128 generator with scaled output
module xorshift import xorshift_pkg::*; #(
   parameter word_t SEED_X = DEF_X,
   parameter word_t SEED_Y = DEF_Y,
   parameter word_t SEED_Z = DEF_Z,
   parameter word_t SEED_W = DEF_W,
   parameter int    RANGE  = 6
) (
   input  logic        clk,
   input  logic        rst,
   output word_t       rand_word,
   output logic [15:0] rand_range,
   output logic        valid
);
   localparam bit    ZS = (SEED_X | SEED_Y | SEED_Z | SEED_W) == 32'd0;
   localparam word_t SX = ZS ? DEF_X : SEED_X;
   localparam word_t SY = ZS ? DEF_Y : SEED_Y;
   localparam word_t SZ = ZS ? DEF_Z : SEED_Z;
   localparam word_t SW = ZS ? DEF_W : SEED_W;
   word_t x, y, z, w;
   logic [127:0] nxt;
   logic [47:0] prod;
   xorshift128_step u_step (.s({x, y, z, w}), .n(nxt));
   // advance the state every cycle; reset loads the seeds without a clock
   always_ff @(posedge clk or posedge rst)
      if (rst) {x, y, z, w} <= {SX, SY, SZ, SW};
      else {x, y, z, w} <= nxt;
   // valid marks that w no longer holds the seed
   always_ff @(posedge clk or posedge rst)
      if (rst) valid <= 1'b0;
      else valid <= 1'b1;
   assign prod = {16'd0, w} * 48'(RANGE);
   assign rand_word = w;
   assign rand_range = prod[47:32];
endmodule

// File: tb/tb_xorshift.sv
// tb_xorshift: checks xorshift against a reference model and known sequence values
module tb_xorshift;
   logic clk, rst;
   logic [31:0] r0, r1, r2;
   logic [15:0] g0, g1, g2;
   logic v0, v1, v2;
   int compared = 0, mismatched = 0;
   logic [31:0] mx, my, mz, mw;

   xorshift d0 (.clk(clk), .rst(rst), .rand_word(r0), .rand_range(g0), .valid(v0));
   xorshift #(.SEED_X(0), .SEED_Y(0), .SEED_Z(0), .SEED_W(0)) d1
      (.clk(clk), .rst(rst), .rand_word(r1), .rand_range(g1), .valid(v1));
   xorshift #(.RANGE(1)) d2 (.clk(clk), .rst(rst), .rand_word(r2), .rand_range(g2), .valid(v2));

   initial begin
      clk = 1'bx;
      #30 clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic mseed();
      {mx, my, mz, mw} = {32'd123456789, 32'd362436069, 32'd521288629, 32'd88675123};
   endtask

   task automatic madvance();
      logic [31:0] t;
      t = mx ^ (mx << 11);
      mx = my; my = mz; mz = mw;
      mw = mw ^ (mw >> 19) ^ t ^ (t >> 8);
   endtask

   function automatic logic [15:0] scale(input logic [31:0] v, input int r);
      logic [63:0] p;
      p = 64'(v) * 64'(r);
      return p[47:32];
   endfunction

   task automatic cycle_check(input string tag);
      @(posedge clk); #1;
      madvance();
      chk({tag, "_rand"}, 64'(r0), 64'(mw));
      chk({tag, "_range"}, 64'(g0), 64'(scale(mw, 6)));
      chk({tag, "_lt6"}, 64'(g0 < 16'd6), 64'd1);
      chk({tag, "_valid"}, 64'(v0), 64'd1);
      chk({tag, "_zero_seed_rand"}, 64'(r1), 64'(mw));
      chk({tag, "_range1"}, 64'(g2), 64'd0);
      chk({tag, "_nonzero"}, 64'({d0.x, d0.y, d0.z, d0.w} != 128'd0), 64'd1);
   endtask

   task automatic reset_check(input string tag);
      chk({tag, "_rand"}, 64'(r0), 64'd88675123);
      chk({tag, "_valid"}, 64'(v0), 64'd0);
      chk({tag, "_range"}, 64'(g0), 64'd0);
      chk({tag, "_zs_rand"}, 64'(r1), 64'd88675123);
      chk({tag, "_zs_valid"}, 64'(v1), 64'd0);
      chk({tag, "_r1_range"}, 64'(g2), 64'd0);
   endtask

   initial begin
      int n;
      rst = 1'b1;
      #28 reset_check("reset_xclk");
      mseed();
      #4 rst = 1'b0;
      @(posedge clk); #1;
      chk("edge1_rand", 64'(r0), 64'd3701687786);
      chk("edge1_range", 64'(g0), 64'd5);
      chk("edge1_valid", 64'(v0), 64'd1);
      madvance();
      @(posedge clk); #1;
      chk("edge2_rand", 64'(r0), 64'd458299110);
      chk("edge2_range", 64'(g0), 64'd0);
      madvance();
      @(posedge clk); #1;
      chk("edge3_rand", 64'(r0), 64'd2500872618);
      madvance();
      for (int i = 0; i < 97; i++) cycle_check("run");
      @(posedge clk);
      #($urandom_range(4, 1)) rst = 1'b1;
      #1 reset_check("async_reset");
      repeat ($urandom_range(3, 1)) @(posedge clk);
      #1 reset_check("held_reset");
      @(negedge clk) rst = 1'b0;
      mseed();
      @(posedge clk); #1;
      madvance();
      chk("restart_rand", 64'(r0), 64'd3701687786);
      chk("restart_model", 64'(r0), 64'(mw));
      chk("restart_zs_rand", 64'(r1), 64'd3701687786);
      n = $urandom_range(60, 20);
      for (int i = 0; i < n; i++) cycle_check("rerun");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
